line_fetch_scheduler: RTL and testbench

LINE_FETCH_SCHEDULER -- requirements
Module: line_fetch_scheduler

---
 rtl/video_timing_pkg.sv | 24 ++
 rtl/line_addr_gen.sv | 57 +++++
 rtl/line_fetch_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_line_fetch_scheduler.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared video timing defaults, line-fetch constants and the fetch FSM state type
// for the line fetch scheduler.
package video_timing_pkg;

    localparam int H_ACTIVE_DEF        = 1280;
    localparam int H_TOTAL_DEF         = 1650;
    localparam int V_ACTIVE_DEF        = 720;
    localparam int V_TOTAL_DEF         = 750;
    localparam int BURST_WORDS_DEF     = 64;
    localparam int BURSTS_PER_LINE_DEF = 5;
    localparam int ADDR_W              = 24;
    localparam int WORDS_PER_LINE_DEF  = BURST_WORDS_DEF * BURSTS_PER_LINE_DEF;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQ       = 2'd1,
        ST_WAIT_DONE = 2'd2
    } fetch_state_e;

    function automatic logic [ADDR_W-1:0] words_per_line(input int burst_words, input int bursts);
        return ADDR_W'(burst_words * bursts);
    endfunction

endpackage

// File: rtl/line_addr_gen.sv
// Frame buffer word address accumulator: reloads the base on line-0 triggers,
// steps one line per other trigger and one burst per completed burst.
module line_addr_gen
    import video_timing_pkg::*;
#(
    parameter int BURST_WORDS     = BURST_WORDS_DEF,
    parameter int BURSTS_PER_LINE = BURSTS_PER_LINE_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load_base,
    input  logic              i_adv_line,
    input  logic              i_start,
    input  logic              i_adv_burst,
    input  logic [ADDR_W-1:0] i_base,
    output logic [ADDR_W-1:0] o_addr
);

    localparam logic [ADDR_W-1:0] STEP_LINE  = words_per_line(BURST_WORDS, BURSTS_PER_LINE);
    localparam logic [ADDR_W-1:0] STEP_BURST = ADDR_W'(BURST_WORDS);

    logic [ADDR_W-1:0] r_line_start;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_next_line_start;

    // Line start tracks every trigger so a dropped fetch does not skew later lines.
    always_comb begin
        w_next_line_start = r_line_start;
        if (i_load_base) begin
            w_next_line_start = i_base;
        end else if (i_adv_line) begin
            w_next_line_start = r_line_start + STEP_LINE;
        end else begin
            w_next_line_start = r_line_start;
        end
    end

    // Line start and current burst address registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_line_start <= {ADDR_W{1'b0}};
            r_addr       <= {ADDR_W{1'b0}};
        end else begin
            r_line_start <= w_next_line_start;
            if (i_start) begin
                r_addr <= w_next_line_start;
            end else if (i_adv_burst) begin
                r_addr <= r_addr + STEP_BURST;
            end else begin
                r_addr <= r_addr;
            end
        end
    end

    assign o_addr = r_addr;

endmodule

// File: rtl/line_fetch_scheduler.sv
// Schedules one line of frame-buffer burst reads ahead of the raster and flags underflow.
// Optional FETCH_STATS_EN adds frame_count / underflow_count outputs.
module line_fetch_scheduler
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE        = H_ACTIVE_DEF,
    parameter int V_ACTIVE        = V_ACTIVE_DEF,
    parameter int V_TOTAL         = V_TOTAL_DEF,
    parameter int BURST_WORDS     = BURST_WORDS_DEF,
    parameter int BURSTS_PER_LINE = BURSTS_PER_LINE_DEF
) (
    input  logic              clk_pix,
    input  logic              rst,
    input  logic [10:0]       counterX,
    input  logic [9:0]        counterY,
    input  logic              enable,
    input  logic [ADDR_W-1:0] fb_base,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic              rd_done,
    output logic [9:0]        fetch_line,
    output logic              line_done,
    output logic              underflow,
    input  logic              underflow_clr
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]       frame_count,
    output logic [15:0]       underflow_count
`endif
);

    localparam int               CNT_W      = $clog2(BURSTS_PER_LINE + 1);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURSTS_PER_LINE);
    localparam logic [10:0]      X_TRIG     = 11'(H_ACTIVE);
    localparam logic [9:0]       Y_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]       Y_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0]       Y_ACT_LAST = 10'(V_ACTIVE - 1);

    fetch_state_e     r_state;
    fetch_state_e     w_state_next;
    logic [CNT_W-1:0] r_burst_cnt;
    logic [9:0]       r_fetch_line;
    logic [9:0]       r_done_line;
    logic             r_done_valid;
    logic             r_rd_req;
    logic             r_line_done;
    logic             r_underflow;

    logic             w_line0;
    logic             w_trig;
    logic [9:0]       w_target;
    logic             w_start;
    logic             w_drop;
    logic             w_burst_more;
    logic             w_adv_burst;
    logic             w_finish;
    logic             w_line_ready;
    logic             w_uf_set;
    logic [ADDR_W-1:0] w_addr;

    // Trigger decode, burst bookkeeping strobes and underflow detection.
    always_comb begin
        w_line0      = (counterY == Y_LAST);
        w_trig       = (counterX == X_TRIG) && enable && (w_line0 || (counterY < Y_ACT_LAST));
        w_target     = w_line0 ? 10'd0 : (counterY + 10'd1);
        w_start      = (r_state == ST_IDLE) && w_trig;
        w_drop       = (r_state != ST_IDLE) && w_trig;
        w_burst_more = (r_burst_cnt < BURST_LAST);
        w_adv_burst  = (r_state == ST_WAIT_DONE) && rd_done && w_burst_more;
        w_finish     = (r_state == ST_WAIT_DONE) && rd_done && !w_burst_more;
        w_line_ready = (r_state == ST_IDLE) && r_done_valid && (r_done_line == counterY);
        w_uf_set     = w_drop || ((counterX == 11'd0) && (counterY < Y_ACT) && !w_line_ready);
    end

    // Fetch FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_trig) begin
                    w_state_next = ST_REQ;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (rd_ack) begin
                    w_state_next = ST_WAIT_DONE;
                end else begin
                    w_state_next = ST_REQ;
                end
            end
            ST_WAIT_DONE: begin
                if (w_adv_burst) begin
                    w_state_next = ST_REQ;
                end else if (w_finish) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_WAIT_DONE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Fetch FSM state register.
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Registered request/line outputs, burst counter and completed-line tracking.
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            r_rd_req     <= 1'b0;
            r_line_done  <= 1'b0;
            r_burst_cnt  <= {CNT_W{1'b0}};
            r_fetch_line <= 10'd0;
            r_done_line  <= 10'd0;
            r_done_valid <= 1'b0;
        end else begin
            r_rd_req    <= (w_state_next == ST_REQ);
            r_line_done <= w_finish;
            if (w_start) begin
                r_burst_cnt  <= CNT_W'(1);
                r_fetch_line <= w_target;
                r_done_valid <= 1'b0;
            end else if (w_adv_burst) begin
                r_burst_cnt <= r_burst_cnt + CNT_W'(1);
            end else if (w_finish) begin
                r_burst_cnt  <= {CNT_W{1'b0}};
                r_done_line  <= r_fetch_line;
                r_done_valid <= 1'b1;
            end else begin
                r_burst_cnt <= r_burst_cnt;
            end
        end
    end

    // Sticky underflow; a same-cycle set wins over clear.
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            r_underflow <= 1'b0;
        end else if (w_uf_set) begin
            r_underflow <= 1'b1;
        end else if (underflow_clr) begin
            r_underflow <= 1'b0;
        end else begin
            r_underflow <= r_underflow;
        end
    end

    line_addr_gen #(
        .BURST_WORDS     (BURST_WORDS),
        .BURSTS_PER_LINE (BURSTS_PER_LINE)
    ) u_addr_gen (
        .i_clk       (clk_pix),
        .i_rst       (rst),
        .i_load_base (w_trig && w_line0),
        .i_adv_line  (w_trig && !w_line0),
        .i_start     (w_start),
        .i_adv_burst (w_adv_burst),
        .i_base      (fb_base),
        .o_addr      (w_addr)
    );

`ifdef FETCH_STATS_EN
    logic [15:0] r_frame_count;
    logic [15:0] r_underflow_count;

    // Frame counter wraps; underflow event counter saturates.
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            r_frame_count     <= 16'd0;
            r_underflow_count <= 16'd0;
        end else begin
            if (w_trig && w_line0) begin
                r_frame_count <= r_frame_count + 16'd1;
            end else begin
                r_frame_count <= r_frame_count;
            end
            if (w_uf_set && (r_underflow_count != 16'hFFFF)) begin
                r_underflow_count <= r_underflow_count + 16'd1;
            end else begin
                r_underflow_count <= r_underflow_count;
            end
        end
    end

    assign frame_count     = r_frame_count;
    assign underflow_count = r_underflow_count;
`endif

    assign rd_req     = r_rd_req;
    assign rd_addr    = w_addr;
    assign fetch_line = r_fetch_line;
    assign line_done  = r_line_done;
    assign underflow  = r_underflow;

endmodule

// File: tb/tb_line_fetch_scheduler.sv
// Directed self-checking bench for line_fetch_scheduler (stats checks when FETCH_STATS_EN is defined).
module tb_line_fetch_scheduler;

    logic        clk_pix = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] counterX = 11'd100;
    logic [9:0]  counterY = 10'd740;
    logic        enable = 1'b1;
    logic [23:0] fb_base = 24'h000000;
    logic        rd_req;
    logic [23:0] rd_addr;
    logic        rd_ack = 1'b0;
    logic        rd_done = 1'b0;
    logic [9:0]  fetch_line;
    logic        line_done;
    logic        underflow;
    logic        underflow_clr = 1'b0;
`ifdef FETCH_STATS_EN
    logic [15:0] frame_count;
    logic [15:0] underflow_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    line_fetch_scheduler dut (
        .clk_pix       (clk_pix),
        .rst           (rst),
        .counterX      (counterX),
        .counterY      (counterY),
        .enable        (enable),
        .fb_base       (fb_base),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_ack        (rd_ack),
        .rd_done       (rd_done),
        .fetch_line    (fetch_line),
        .line_done     (line_done),
        .underflow     (underflow),
        .underflow_clr (underflow_clr)
`ifdef FETCH_STATS_EN
        ,
        .frame_count     (frame_count),
        .underflow_count (underflow_count)
`endif
    );

    always #5 clk_pix = ~clk_pix;

    task automatic step();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called while in REQ for burst 'first'; runs remaining bursts with immediate ack/done.
    task automatic do_bursts(input logic [23:0] start, input int first);
        for (int b = first; b < 5; b++) begin
            chk("burst_req_hi", {31'd0, rd_req}, 32'd1);
            chk("burst_addr", {8'd0, rd_addr}, {8'd0, start + 24'(64 * b)});
            rd_ack = 1'b1;
            step();
            rd_ack = 1'b0;
            chk("burst_req_lo", {31'd0, rd_req}, 32'd0);
            rd_done = 1'b1;
            step();
            rd_done = 1'b0;
            chk("line_done_at_end", {31'd0, line_done}, (b == 4) ? 32'd1 : 32'd0);
        end
        step();
        chk("line_done_one_cycle", {31'd0, line_done}, 32'd0);
        chk("idle_after_line", {31'd0, rd_req}, 32'd0);
    endtask

    task automatic trigger(input logic [9:0] y);
        counterX = 11'd1280;
        counterY = y;
        step();
        counterX = 11'd100;
        counterY = 10'd740;
    endtask

    initial begin
        // Reset values
        step();
        step();
        chk("rst_rd_req", {31'd0, rd_req}, 32'd0);
        chk("rst_rd_addr", {8'd0, rd_addr}, 32'd0);
        chk("rst_fetch_line", {22'd0, fetch_line}, 32'd0);
        chk("rst_line_done", {31'd0, line_done}, 32'd0);
        chk("rst_underflow", {31'd0, underflow}, 32'd0);
        rst = 1'b0;
        step();

        // Line-0 fetch from the last blanking line
        fb_base = 24'h100000;
        trigger(10'd749);
        chk("l0_fetch_line", {22'd0, fetch_line}, 32'd0);
        do_bursts(24'h100000, 0);
        chk("l0_no_underflow", {31'd0, underflow}, 32'd0);

        // Line 1 after line 0; Y=719 is not a trigger
        trigger(10'd0);
        chk("l1_fetch_line", {22'd0, fetch_line}, 32'd1);
        do_bursts(24'h100140, 0);
        trigger(10'd719);
        step();
        chk("y719_no_req", {31'd0, rd_req}, 32'd0);
        chk("y719_fetch_line", {22'd0, fetch_line}, 32'd1);

        // Underflow at X=0: line 1 ready, line 2 not fetched
        counterX = 11'd0;
        counterY = 10'd1;
        step();
        chk("uf_line_ready", {31'd0, underflow}, 32'd0);
        counterY = 10'd2;
        step();
        counterX = 11'd100;
        counterY = 10'd740;
        chk("uf_line_missing", {31'd0, underflow}, 32'd1);
        underflow_clr = 1'b1;
        step();
        underflow_clr = 1'b0;
        chk("uf_cleared", {31'd0, underflow}, 32'd0);

        // Withheld ack: request and address hold; stray rd_done ignored in REQ
        trigger(10'd1);
        for (int i = 0; i < 10; i++) begin
            rd_done = (i == 4);
            chk("hold_req", {31'd0, rd_req}, 32'd1);
            chk("hold_addr", {8'd0, rd_addr}, 32'h00100280);
            step();
        end
        rd_done = 1'b0;
        rd_ack = 1'b1;
        step();
        chk("ack_deassert", {31'd0, rd_req}, 32'd0);
        step();
        chk("stray_ack_ignored", {31'd0, rd_req}, 32'd0);
        rd_ack = 1'b0;
        step();
        chk("wait_addr_stable", {8'd0, rd_addr}, 32'h00100280);
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
        do_bursts(24'h100280, 1);

        // Dropped trigger while busy, then set-vs-clear at X wrap
        trigger(10'd2);
        rd_ack = 1'b1;
        step();
        rd_ack = 1'b0;
        trigger(10'd3);
        chk("drop_sets_uf", {31'd0, underflow}, 32'd1);
        chk("drop_keeps_line", {22'd0, fetch_line}, 32'd3);
        underflow_clr = 1'b1;
        step();
        chk("drop_uf_cleared", {31'd0, underflow}, 32'd0);
        counterX = 11'd0;
        counterY = 10'd3;
        step();
        counterX = 11'd100;
        counterY = 10'd740;
        chk("set_beats_clear", {31'd0, underflow}, 32'd1);
        step();
        underflow_clr = 1'b0;
        chk("uf_cleared_again", {31'd0, underflow}, 32'd0);
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
        do_bursts(24'h1003C0, 1);

        // Enable low blocks triggers but never aborts an in-flight fetch
        enable = 1'b0;
        trigger(10'd4);
        step();
        chk("disabled_no_req", {31'd0, rd_req}, 32'd0);
        enable = 1'b1;
        trigger(10'd4);
        chk("l5_fetch_line", {22'd0, fetch_line}, 32'd5);
        enable = 1'b0;
        do_bursts(24'h100640, 0);
        enable = 1'b1;

        // Asynchronous reset in WAIT_DONE after three bursts
        fb_base = 24'h200000;
        trigger(10'd749);
        for (int b = 0; b < 3; b++) begin
            rd_ack = 1'b1;
            step();
            rd_ack = 1'b0;
            if (b < 2) begin
                rd_done = 1'b1;
                step();
                rd_done = 1'b0;
            end
        end
        chk("pre_rst_addr", {8'd0, rd_addr}, 32'h00200080);
        rst = 1'b1;
        #1;
        chk("async_rd_req", {31'd0, rd_req}, 32'd0);
        chk("async_rd_addr", {8'd0, rd_addr}, 32'd0);
        chk("async_fetch_line", {22'd0, fetch_line}, 32'd0);
        chk("async_line_done", {31'd0, line_done}, 32'd0);
        step();
        rst = 1'b0;
        fb_base = 24'h300000;
        trigger(10'd749);
        do_bursts(24'h300000, 0);

        // Two more frames and one forced underflow event
        trigger(10'd749);
        do_bursts(24'h300000, 0);
        trigger(10'd749);
        do_bursts(24'h300000, 0);
        counterX = 11'd0;
        counterY = 10'd5;
        step();
        counterX = 11'd100;
        counterY = 10'd740;
        chk("forced_uf", {31'd0, underflow}, 32'd1);
`ifdef FETCH_STATS_EN
        chk("frame_count", {16'd0, frame_count}, 32'd3);
        chk("underflow_count", {16'd0, underflow_count}, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
